// File: rtl/fwd_sel_gen_pkg.sv
// Shared definitions for the EXE-stage forwarding-select generator:
// select encoding, address width and the pipeline-slot record.
package fwd_sel_gen_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int SEL_W      = 2;

    localparam logic [SEL_W-1:0] SEL_REG = 2'b00;
    localparam logic [SEL_W-1:0] SEL_MEM = 2'b01;
    localparam logic [SEL_W-1:0] SEL_WB  = 2'b10;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // A bubble (wb_en=0) never matches, so it can neither forward nor stall.
    function automatic logic slot_hits(input slot_t s, input logic [REG_ADDR_W-1:0] r);
        return s.wb_en && (s.dest == r);
    endfunction

endpackage

// File: rtl/fwd_sel_gen_logic.sv
// Priority compare for one EXE operand: MEM result first, then WB data,
// otherwise the register-file value.
module fwd_sel_logic
    import fwd_sel_gen_pkg::*;
(
    input  logic                  forward_en,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  src_used,
    input  slot_t                 mem_slot,
    input  slot_t                 wb_slot,
    output logic [SEL_W-1:0]      sel
);

    always_comb begin
        sel = SEL_REG;
        if (forward_en && src_used) begin
            // A load sitting in MEM has no data yet; fall through to WB.
            if (slot_hits(mem_slot, src) && !mem_slot.mem_read) begin
                sel = SEL_MEM;
            end else if (slot_hits(wb_slot, src)) begin
                sel = SEL_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_sel_gen.sv
// Forwarding-select and stall-request generator for a 5-stage pipeline:
// tracks the EXE/MEM/WB slots and drives the two EXE operand-mux selects.
module fwd_sel_gen
    import fwd_sel_gen_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_en,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic                  id_src1_valid,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [SEL_W-1:0]      sel_a,
    output logic [SEL_W-1:0]      sel_b,
    output logic                  hazard
);

    slot_t                 exe_slot;
    slot_t                 mem_slot;
    slot_t                 wb_slot;
    logic [REG_ADDR_W-1:0] exe_src1;
    logic [REG_ADDR_W-1:0] exe_src2;
    logic                  exe_src1_valid;
    logic                  exe_two_src;

    logic id_uses_exe;
    logic id_uses_mem;

    always_comb begin
        id_uses_exe = (id_src1_valid && slot_hits(exe_slot, id_src1)) ||
                      (id_two_src    && slot_hits(exe_slot, id_src2));
        id_uses_mem = (id_src1_valid && slot_hits(mem_slot, id_src1)) ||
                      (id_two_src    && slot_hits(mem_slot, id_src2));
        if (forward_en) begin
            hazard = id_uses_exe && exe_slot.mem_read;
        end else begin
            hazard = id_uses_exe || id_uses_mem;
        end
    end

    // flush and hazard together still insert exactly one bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_slot       <= SLOT_EMPTY;
            mem_slot       <= SLOT_EMPTY;
            wb_slot        <= SLOT_EMPTY;
            exe_src1       <= '0;
            exe_src2       <= '0;
            exe_src1_valid <= 1'b0;
            exe_two_src    <= 1'b0;
        end else begin
            mem_slot <= exe_slot;
            wb_slot  <= mem_slot;
            if (flush || hazard) begin
                exe_slot       <= SLOT_EMPTY;
                exe_src1       <= '0;
                exe_src2       <= '0;
                exe_src1_valid <= 1'b0;
                exe_two_src    <= 1'b0;
            end else begin
                exe_slot.dest     <= id_dest;
                exe_slot.wb_en    <= id_wb_en;
                exe_slot.mem_read <= id_mem_read;
                exe_src1          <= id_src1;
                exe_src2          <= id_src2;
                exe_src1_valid    <= id_src1_valid;
                exe_two_src       <= id_two_src;
            end
        end
    end

    fwd_sel_logic u_sel_a (
        .forward_en (forward_en),
        .src        (exe_src1),
        .src_used   (exe_src1_valid),
        .mem_slot   (mem_slot),
        .wb_slot    (wb_slot),
        .sel        (sel_a)
    );

    fwd_sel_logic u_sel_b (
        .forward_en (forward_en),
        .src        (exe_src2),
        .src_used   (exe_two_src),
        .mem_slot   (mem_slot),
        .wb_slot    (wb_slot),
        .sel        (sel_b)
    );

endmodule

// File: tb/tb_fwd_sel_gen.sv
// Self-checking bench for fwd_sel_gen: directed hazard scenarios followed by
// random instruction streams compared against an in-flight-instruction model.
module tb_fwd_sel_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       forward_en = 1'b1;
    logic [3:0] id_src1 = '0;
    logic [3:0] id_src2 = '0;
    logic       id_two_src = 1'b0;
    logic       id_src1_valid = 1'b0;
    logic [3:0] id_dest = '0;
    logic       id_wb_en = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       hazard;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] dest;
        bit         wb;
        bit         ld;
        logic [3:0] s1;
        bit         v1;
        logic [3:0] s2;
        bit         v2;
    } ins_t;

    // pipe[0] = instruction in EXE, pipe[1] = MEM, pipe[2] = WB
    ins_t pipe [3];
    ins_t nop_i;
    bit   last_haz;

    fwd_sel_gen dut (
        .clk           (clk),
        .rst           (rst),
        .forward_en    (forward_en),
        .id_src1       (id_src1),
        .id_src2       (id_src2),
        .id_two_src    (id_two_src),
        .id_src1_valid (id_src1_valid),
        .id_dest       (id_dest),
        .id_wb_en      (id_wb_en),
        .id_mem_read   (id_mem_read),
        .flush         (flush),
        .sel_a         (sel_a),
        .sel_b         (sel_b),
        .hazard        (hazard)
    );

    always #5 clk = ~clk;

    function automatic ins_t mk(input int d, input bit wb, input bit ld,
                                input int s1, input bit v1, input int s2, input bit v2);
        ins_t r;
        r.dest = 4'(d); r.wb = wb; r.ld = ld;
        r.s1 = 4'(s1); r.v1 = v1; r.s2 = 4'(s2); r.v2 = v2;
        return r;
    endfunction

    // Youngest older producer of the register wins; a load one stage ahead has no data yet.
    function automatic logic [1:0] exp_sel(input logic [3:0] src, input bit used);
        if (!forward_en || !used) return 2'd0;
        for (int age = 1; age <= 2; age++) begin
            if (pipe[age].wb && pipe[age].dest == src) begin
                if (age == 1 && pipe[age].ld) continue;
                return (age == 1) ? 2'd1 : 2'd2;
            end
        end
        return 2'd0;
    endfunction

    // With forwarding only a load directly ahead stalls; without it any producer
    // still in EXE or MEM does.
    function automatic bit exp_haz(input ins_t i);
        int depth;
        bit reads;
        depth = forward_en ? 1 : 2;
        for (int age = 0; age < depth; age++) begin
            reads = (i.v1 && i.s1 == pipe[age].dest) || (i.v2 && i.s2 == pipe[age].dest);
            if (pipe[age].wb && reads && (!forward_en || pipe[age].ld)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) pipe[k] = nop_i;
    endtask

    // Entered just after a rising edge; checks mid-cycle, leaves just after the next edge.
    task automatic step(input ins_t i, input bit fl,
                        output logic [1:0] sa, output logic [1:0] sb, output logic hz);
        bit eh;
        id_dest = i.dest; id_wb_en = i.wb; id_mem_read = i.ld;
        id_src1 = i.s1; id_src1_valid = i.v1; id_src2 = i.s2; id_two_src = i.v2;
        flush = fl;
        #3;
        eh = exp_haz(i);
        chk("sel_a", sel_a, exp_sel(pipe[0].s1, pipe[0].v1));
        chk("sel_b", sel_b, exp_sel(pipe[0].s2, pipe[0].v2));
        chk("hazard", {1'b0, hazard}, {1'b0, eh});
        sa = sel_a; sb = sel_b; hz = hazard;
        last_haz = eh;
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (fl || eh) ? nop_i : i;
        #1;
    endtask

    task automatic drain();
        logic [1:0] a, b;
        logic h;
        for (int k = 0; k < 3; k++) step(nop_i, 1'b0, a, b, h);
    endtask

    initial begin
        logic [1:0] sa, sb;
        logic       hz;
        int         hz_cnt;
        ins_t       cur;

        nop_i = mk(0, 0, 0, 0, 0, 0, 0);
        clear_model();

        // Reset held with busy ID inputs
        id_src1 = 4'(3); id_src2 = 4'(3); id_src1_valid = 1; id_two_src = 1;
        id_dest = 4'(3); id_wb_en = 1; id_mem_read = 1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_sel_a", sel_a, 2'b00);
        chk("rst_sel_b", sel_b, 2'b00);
        chk("rst_hazard", {1'b0, hazard}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        step(nop_i, 0, sa, sb, hz);
        chk("post_rst", {sa | sb, hz}, 3'b000 >> 1);

        // MEM forward: ADD R3 ; SUB R5,R3,R1
        step(mk(3, 1, 0, 1, 1, 2, 1), 0, sa, sb, hz);
        step(mk(5, 1, 0, 3, 1, 1, 1), 0, sa, sb, hz);
        chk("memfwd_hz", {1'b0, hz}, 2'b00);
        step(nop_i, 0, sa, sb, hz);
        chk("memfwd_sel_a", sa, 2'b01);
        chk("memfwd_sel_b", sb, 2'b00);
        drain();

        // WB forward on both operands: MOV R2 ; NOP ; ADD R4,R2,R2
        step(mk(2, 1, 0, 0, 0, 0, 0), 0, sa, sb, hz);
        step(nop_i, 0, sa, sb, hz);
        step(mk(4, 1, 0, 2, 1, 2, 1), 0, sa, sb, hz);
        step(nop_i, 0, sa, sb, hz);
        chk("wbfwd_sel_a", sa, 2'b10);
        chk("wbfwd_sel_b", sb, 2'b10);
        drain();

        // MEM beats WB: MOV R2 ; MOV R2 ; ADD R4,R2
        step(mk(2, 1, 0, 0, 0, 0, 0), 0, sa, sb, hz);
        step(mk(2, 1, 0, 0, 0, 0, 0), 0, sa, sb, hz);
        step(mk(4, 1, 0, 2, 1, 0, 0), 0, sa, sb, hz);
        step(nop_i, 0, sa, sb, hz);
        chk("prio_sel_a", sa, 2'b01);
        drain();

        // Load-use: LDR R7 ; ADD R8,R7,R0
        step(mk(7, 1, 1, 0, 0, 0, 0), 0, sa, sb, hz);
        hz_cnt = 0;
        cur = mk(8, 1, 0, 7, 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            step(cur, 0, sa, sb, hz);
            if (hz === 1'b1) hz_cnt++;
            if (hz !== 1'b1) break;
        end
        chk("ldu_hz_cycles", 2'(hz_cnt), 2'd1);
        step(nop_i, 0, sa, sb, hz);
        chk("ldu_sel_a", sa, 2'b10);
        drain();

        // Forwarding disabled: ADD R3 ; SUB R5,R3
        forward_en = 1'b0;
        step(mk(3, 1, 0, 0, 0, 0, 0), 0, sa, sb, hz);
        hz_cnt = 0;
        cur = mk(5, 1, 0, 3, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step(cur, 0, sa, sb, hz);
            if (hz === 1'b1) hz_cnt++;
            if (hz !== 1'b1) break;
        end
        chk("nofwd_hz_cycles", 2'(hz_cnt), 2'd2);
        step(nop_i, 0, sa, sb, hz);
        chk("nofwd_sel_a", sa, 2'b00);
        drain();
        forward_en = 1'b1;

        // Flush kills ADD R9 on its way into EXE
        step(mk(9, 1, 0, 0, 0, 0, 0), 1, sa, sb, hz);
        step(mk(10, 1, 0, 9, 1, 9, 1), 0, sa, sb, hz);
        chk("flush_hz", {1'b0, hz}, 2'b00);
        step(nop_i, 0, sa, sb, hz);
        chk("flush_sel_a", sa, 2'b00);
        drain();

        // Random streams; a stalled instruction is re-presented until it issues
        cur = nop_i;
        for (int n = 0; n < 300; n++) begin
            if (!last_haz) begin
                cur = mk($urandom_range(3), $urandom_range(1), $urandom_range(1),
                         $urandom_range(3), $urandom_range(1),
                         $urandom_range(3), $urandom_range(1));
                if ($urandom_range(15) == 0) forward_en = ~forward_en;
            end
            step(cur, ($urandom_range(7) == 0), sa, sb, hz);

            if (n == 150) begin
                // Asynchronous reset mid-stream
                #2; rst = 1'b0; #1;
                chk("midrst_sel_a", sel_a, 2'b00);
                chk("midrst_sel_b", sel_b, 2'b00);
                chk("midrst_hazard", {1'b0, hazard}, 2'b00);
                clear_model();
                last_haz = 0;
                @(posedge clk); #1;
                rst = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
